// File: rtl/frame_dispatch_pkg.sv
// Shared state encoding, header/pointer field positions and defaults for frame_dispatch.
package frame_dispatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR2,
    ST_DATA,
    ST_COMMIT,
    ST_DISCARD
  } state_t;

  localparam int MAX_LEN_DEF   = 1518;
  localparam int BP_THRESH_DEF = 1600;

  // First header byte: {len[11:8], portmap[3:0]}
  localparam int HDR_MAP_LSB = 0;
  localparam int HDR_MAP_MSB = 3;
  localparam int HDR_LEN_LSB = 4;
  localparam int HDR_LEN_MSB = 7;

  // Pointer word: {err, portmap[3:0], frame_len[10:0]}
  localparam int ERR_BIT = 15;
  localparam int MAP_MSB = 14;
  localparam int MAP_LSB = 11;
  localparam int LEN_MSB = 10;
  localparam int LEN_LSB = 0;

  function automatic logic [15:0] make_ptr(input logic err, input logic [3:0] map,
                                           input logic [10:0] len);
    logic [15:0] w;
    w                  = '0;
    w[ERR_BIT]         = err;
    w[MAP_MSB:MAP_LSB] = map;
    w[LEN_MSB:LEN_LSB] = len;
    return w;
  endfunction

endpackage

// File: rtl/frame_dispatch_admit.sv
// Combinational admission mask: a port takes the frame only if it is mapped, its pointer
// FIFO has room and its data FIFO can hold the whole frame.
module frame_admit
  import frame_dispatch_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic [3:0]       portmap,
  input  logic [3:0]       ptr_full,
  input  logic [3:0][11:0] space,
  input  logic [11:0]      frame_len,
  output logic [3:0]       admit
);

  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);

  logic len_ok;
  assign len_ok = (frame_len != 12'd0) && (frame_len <= MAX_LEN_W);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_admit
      assign admit[gi] = len_ok && portmap[gi] && !ptr_full[gi] && (space[gi] >= frame_len);
    end
  endgenerate

endmodule

// File: rtl/frame_dispatch.sv
// Consumes the sof/dv/data frame stream, multicasts frame bytes into up to four egress data
// FIFOs, strips pad and commits one pointer word per admitted port.
module frame_dispatch
  import frame_dispatch_pkg::*;
#(
  parameter int MAX_LEN   = MAX_LEN_DEF,
  parameter int BP_THRESH = BP_THRESH_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sof,
  input  logic        dv,
  input  logic [7:0]  data,
  output logic        bp0,
  output logic        bp1,
  output logic        bp2,
  output logic        bp3,
  input  logic [11:0] dfifo_space0,
  input  logic [11:0] dfifo_space1,
  input  logic [11:0] dfifo_space2,
  input  logic [11:0] dfifo_space3,
  input  logic [3:0]  ptr_full,
  output logic [3:0]  dfifo_wr,
  output logic [7:0]  dfifo_din,
  output logic [3:0]  ptr_wr,
  output logic [15:0] ptr_din,
  output logic        frame_drop
);

  localparam logic [11:0] BP_THRESH_W = 12'(BP_THRESH);

  state_t      state_reg, state_next;
  logic [3:0]  portmap_reg, portmap_next;
  logic [3:0]  len_hi_reg, len_hi_next;
  logic [10:0] frame_len_reg, frame_len_next;
  logic [10:0] byte_cnt_reg, byte_cnt_next;
  logic [3:0]  admit_reg, admit_next;
  logic        err_reg, err_next;
  logic [3:0]  dfifo_wr_reg, dfifo_wr_next;
  logic [7:0]  dfifo_din_reg, dfifo_din_next;
  logic [3:0]  ptr_wr_reg, ptr_wr_next;
  logic [15:0] ptr_din_reg, ptr_din_next;
  logic        frame_drop_reg, frame_drop_next;
  logic [3:0]  bp_reg, bp_next;

  logic [3:0][11:0] space_all;
  logic [11:0]      hdr_len;
  logic [3:0]       admit_mask;

  assign space_all = {dfifo_space3, dfifo_space2, dfifo_space1, dfifo_space0};
  // Header length includes the two header bytes; only meaningful in HDR2.
  assign hdr_len   = {len_hi_reg, data} - 12'd2;

  frame_admit #(
    .MAX_LEN (MAX_LEN)
  ) u_admit (
    .portmap   (portmap_reg),
    .ptr_full  (ptr_full),
    .space     (space_all),
    .frame_len (hdr_len),
    .admit     (admit_mask)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bp
      assign bp_next[gi] = space_all[gi] < BP_THRESH_W;
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    portmap_next    = portmap_reg;
    len_hi_next     = len_hi_reg;
    frame_len_next  = frame_len_reg;
    byte_cnt_next   = byte_cnt_reg;
    admit_next      = admit_reg;
    err_next        = err_reg;
    dfifo_wr_next   = '0;
    dfifo_din_next  = dfifo_din_reg;
    ptr_wr_next     = '0;
    ptr_din_next    = ptr_din_reg;
    frame_drop_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (sof && dv) begin
          portmap_next = data[HDR_MAP_MSB:HDR_MAP_LSB];
          len_hi_next  = data[HDR_LEN_MSB:HDR_LEN_LSB];
          state_next   = ST_HDR2;
        end
      end

      ST_HDR2: begin
        if (!dv) begin
          state_next = ST_IDLE;
        end else begin
          frame_len_next = hdr_len[10:0];
          admit_next     = admit_mask;
          byte_cnt_next  = '0;
          err_next       = 1'b0;
          if (admit_mask == 4'd0) begin
            frame_drop_next = 1'b1;
            state_next      = ST_DISCARD;
          end else begin
            state_next = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (sof && dv) begin
          // A new frame cut this one short: commit it as errored and parse the new header.
          ptr_wr_next  = admit_reg;
          ptr_din_next = make_ptr(1'b1, admit_reg, byte_cnt_reg);
          portmap_next = data[HDR_MAP_MSB:HDR_MAP_LSB];
          len_hi_next  = data[HDR_LEN_MSB:HDR_LEN_LSB];
          state_next   = ST_HDR2;
        end else if (dv) begin
          dfifo_din_next = data;
          dfifo_wr_next  = admit_reg;
          byte_cnt_next  = byte_cnt_reg + 11'd1;
          if (byte_cnt_reg + 11'd1 == frame_len_reg) state_next = ST_COMMIT;
        end else begin
          err_next   = 1'b1;
          state_next = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        ptr_wr_next  = admit_reg;
        ptr_din_next = make_ptr(err_reg, admit_reg, byte_cnt_reg);
        if (sof && dv) begin
          portmap_next = data[HDR_MAP_MSB:HDR_MAP_LSB];
          len_hi_next  = data[HDR_LEN_MSB:HDR_LEN_LSB];
          state_next   = ST_HDR2;
        end else if (dv) begin
          state_next = ST_DISCARD;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_DISCARD: begin
        if (sof && dv) begin
          portmap_next = data[HDR_MAP_MSB:HDR_MAP_LSB];
          len_hi_next  = data[HDR_LEN_MSB:HDR_LEN_LSB];
          state_next   = ST_HDR2;
        end else if (!dv) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      portmap_reg    <= '0;
      len_hi_reg     <= '0;
      frame_len_reg  <= '0;
      byte_cnt_reg   <= '0;
      admit_reg      <= '0;
      err_reg        <= 1'b0;
      dfifo_wr_reg   <= '0;
      dfifo_din_reg  <= '0;
      ptr_wr_reg     <= '0;
      ptr_din_reg    <= '0;
      frame_drop_reg <= 1'b0;
      bp_reg         <= '0;
    end else begin
      state_reg      <= state_next;
      portmap_reg    <= portmap_next;
      len_hi_reg     <= len_hi_next;
      frame_len_reg  <= frame_len_next;
      byte_cnt_reg   <= byte_cnt_next;
      admit_reg      <= admit_next;
      err_reg        <= err_next;
      dfifo_wr_reg   <= dfifo_wr_next;
      dfifo_din_reg  <= dfifo_din_next;
      ptr_wr_reg     <= ptr_wr_next;
      ptr_din_reg    <= ptr_din_next;
      frame_drop_reg <= frame_drop_next;
      bp_reg         <= bp_next;
    end
  end

  assign dfifo_wr   = dfifo_wr_reg;
  assign dfifo_din  = dfifo_din_reg;
  assign ptr_wr     = ptr_wr_reg;
  assign ptr_din    = ptr_din_reg;
  assign frame_drop = frame_drop_reg;
  assign bp0        = bp_reg[0];
  assign bp1        = bp_reg[1];
  assign bp2        = bp_reg[2];
  assign bp3        = bp_reg[3];

endmodule

// File: tb/tb_frame_dispatch.sv
// Self-checking bench for frame_dispatch: directed scenarios plus randomized frames against a
// transaction-level model of admission, byte copying and pointer commits.
module tb_frame_dispatch;

  logic             clk  = 1'b0;
  logic             rstn = 1'b0;
  logic             sof  = 1'b0;
  logic             dv   = 1'b0;
  logic [7:0]       data = 8'd0;
  logic [3:0][11:0] space_v;
  logic [3:0]       ptr_full_v;
  logic             bp0, bp1, bp2, bp3;
  logic [3:0]       dfifo_wr, ptr_wr;
  logic [7:0]       dfifo_din;
  logic [15:0]      ptr_din;
  logic             frame_drop;
  logic [3:0]       bp_vec;

  int errors = 0;
  int checks = 0;

  int unsigned got_cnt[4]   = '{default: 0};
  int unsigned got_hash[4]  = '{default: 0};
  int unsigned got_pcnt[4]  = '{default: 0};
  int unsigned got_phash[4] = '{default: 0};
  int unsigned got_drop     = 0;
  logic [15:0] got_plast    = '0;
  int unsigned exp_cnt[4]   = '{default: 0};
  int unsigned exp_hash[4]  = '{default: 0};
  int unsigned exp_pcnt[4]  = '{default: 0};
  int unsigned exp_phash[4] = '{default: 0};
  int unsigned exp_drop     = 0;
  int          clr_seq      = 0;
  int          seen_seq     = 0;

  assign bp_vec = {bp3, bp2, bp1, bp0};

  always #5 clk = ~clk;

  frame_dispatch dut (
    .clk          (clk),
    .rstn         (rstn),
    .sof          (sof),
    .dv           (dv),
    .data         (data),
    .bp0          (bp0),
    .bp1          (bp1),
    .bp2          (bp2),
    .bp3          (bp3),
    .dfifo_space0 (space_v[0]),
    .dfifo_space1 (space_v[1]),
    .dfifo_space2 (space_v[2]),
    .dfifo_space3 (space_v[3]),
    .ptr_full     (ptr_full_v),
    .dfifo_wr     (dfifo_wr),
    .dfifo_din    (dfifo_din),
    .ptr_wr       (ptr_wr),
    .ptr_din      (ptr_din),
    .frame_drop   (frame_drop)
  );

  // Observation side: order-sensitive hashes of everything written per port.
  always @(negedge clk) begin
    if (clr_seq != seen_seq) begin
      seen_seq = clr_seq;
      for (int p = 0; p < 4; p++) begin
        got_cnt[p] = 0; got_hash[p] = 0; got_pcnt[p] = 0; got_phash[p] = 0;
      end
      got_drop  = 0;
      got_plast = '0;
    end
    for (int p = 0; p < 4; p++) begin
      if (dfifo_wr[p]) begin
        got_cnt[p]++;
        got_hash[p] = got_hash[p] * 32'd31 + 32'(dfifo_din);
      end
      if (ptr_wr[p]) begin
        got_pcnt[p]++;
        got_phash[p] = got_phash[p] * 32'd31 + 32'(ptr_din);
        got_plast    = ptr_din;
      end
    end
    if (frame_drop) got_drop++;
  end

  task automatic drive(input logic s, input logic v, input logic [7:0] d);
    sof = s; dv = v; data = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic clear_obs();
    clr_seq++;
    for (int p = 0; p < 4; p++) begin
      exp_cnt[p] = 0; exp_hash[p] = 0; exp_pcnt[p] = 0; exp_phash[p] = 0;
    end
    exp_drop = 0;
    idle(1);
  endtask

  // Reference: a port receives the first min(nsend, frame_len) bytes if mapped, its pointer
  // FIFO is not full and its data FIFO holds the whole frame; err marks a short frame.
  task automatic send_frame(input logic [3:0] map, input logic [11:0] len, input int nsend,
                            input int pad, input bit gap);
    logic [11:0] flen;
    logic [3:0]  adm;
    logic [7:0]  b;
    logic [15:0] w;
    bit          ok;
    int          wr;
    flen = len - 12'd2;
    ok   = (flen != 12'd0) && (flen <= 12'd1518);
    for (int p = 0; p < 4; p++)
      adm[p] = ok && map[p] && !ptr_full_v[p] && (space_v[p] >= flen);
    drive(1'b1, 1'b1, {len[11:8], map});
    drive(1'b0, 1'b1, len[7:0]);
    wr = 0;
    for (int k = 0; k < nsend; k++) begin
      b = 8'($urandom);
      drive(1'b0, 1'b1, b);
      if (adm != 4'd0 && k < int'(flen)) begin
        wr++;
        for (int p = 0; p < 4; p++)
          if (adm[p]) begin
            exp_cnt[p]++;
            exp_hash[p] = exp_hash[p] * 32'd31 + 32'(b);
          end
      end
    end
    for (int k = 0; k < pad; k++) drive(1'b0, 1'b1, 8'($urandom));
    if (adm == 4'd0) begin
      exp_drop++;
    end else begin
      w = {(nsend < int'(flen)) ? 1'b1 : 1'b0, adm, 11'(wr)};
      for (int p = 0; p < 4; p++)
        if (adm[p]) begin
          exp_pcnt[p]++;
          exp_phash[p] = exp_phash[p] * 32'd31 + 32'(w);
        end
    end
    if (gap) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_reset();
    space_v = '0; ptr_full_v = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dfifo_wr !== 4'd0) begin errors++; $display("FAIL reset dfifo_wr: got %h expected 0", dfifo_wr); end
    checks++; if (ptr_wr !== 4'd0) begin errors++; $display("FAIL reset ptr_wr: got %h expected 0", ptr_wr); end
    checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL reset frame_drop: got %b expected 0", frame_drop); end
    checks++; if (bp_vec !== 4'd0) begin errors++; $display("FAIL reset bp: got %b expected 0000", bp_vec); end
    rstn = 1'b1;
    idle(1);
    checks++; if (bp_vec !== 4'hF) begin errors++; $display("FAIL reset bp_after_release: got %b expected 1111", bp_vec); end
    space_v = {4{12'd4095}};
    idle(2);
    $display("test_reset done");
  endtask

  task automatic test_unicast();
    clear_obs();
    send_frame(4'h1, 12'h042, 64, 3, 1'b1);
    idle(4);
    checks++; if (got_plast !== 16'h0840) begin errors++; $display("FAIL unicast ptr_din: got %h expected 0840", got_plast); end
    for (int p = 0; p < 4; p++) begin
      checks++; if (got_cnt[p] !== exp_cnt[p]) begin errors++; $display("FAIL unicast wr_cnt[%0d]: got %0d expected %0d", p, got_cnt[p], exp_cnt[p]); end
      checks++; if (got_hash[p] !== exp_hash[p]) begin errors++; $display("FAIL unicast data[%0d]: got %h expected %h", p, got_hash[p], exp_hash[p]); end
      checks++; if (got_pcnt[p] !== exp_pcnt[p]) begin errors++; $display("FAIL unicast ptr_cnt[%0d]: got %0d expected %0d", p, got_pcnt[p], exp_pcnt[p]); end
    end
    checks++; if (got_drop !== exp_drop) begin errors++; $display("FAIL unicast drop: got %0d expected %0d", got_drop, exp_drop); end
    $display("test_unicast: port0 bytes=%0d ptr=%h", got_cnt[0], got_plast);
  endtask

  task automatic test_broadcast();
    clear_obs();
    send_frame(4'hE, 12'h03E, 60, 4, 1'b1);
    idle(4);
    checks++; if (got_plast !== 16'h703C) begin errors++; $display("FAIL broadcast ptr_din: got %h expected 703c", got_plast); end
    for (int p = 0; p < 4; p++) begin
      checks++; if (got_cnt[p] !== exp_cnt[p]) begin errors++; $display("FAIL broadcast wr_cnt[%0d]: got %0d expected %0d", p, got_cnt[p], exp_cnt[p]); end
      checks++; if (got_hash[p] !== exp_hash[p]) begin errors++; $display("FAIL broadcast data[%0d]: got %h expected %h", p, got_hash[p], exp_hash[p]); end
      checks++; if (got_pcnt[p] !== exp_pcnt[p]) begin errors++; $display("FAIL broadcast ptr_cnt[%0d]: got %0d expected %0d", p, got_pcnt[p], exp_pcnt[p]); end
    end
    $display("test_broadcast: port1..3 bytes=%0d/%0d/%0d", got_cnt[1], got_cnt[2], got_cnt[3]);
  endtask

  task automatic test_drop();
    clear_obs();
    space_v[2] = 12'd10;
    send_frame(4'h4, 12'h042, 64, 2, 1'b1);
    idle(4);
    checks++; if (got_drop !== 32'd1) begin errors++; $display("FAIL drop pulses: got %0d expected 1", got_drop); end
    for (int p = 0; p < 4; p++) begin
      checks++; if (got_cnt[p] !== 32'd0) begin errors++; $display("FAIL drop wr_cnt[%0d]: got %0d expected 0", p, got_cnt[p]); end
      checks++; if (got_pcnt[p] !== 32'd0) begin errors++; $display("FAIL drop ptr_cnt[%0d]: got %0d expected 0", p, got_pcnt[p]); end
    end
    space_v[2] = 12'd4095;
    $display("test_drop: drops=%0d", got_drop);
  endtask

  task automatic test_truncate();
    clear_obs();
    send_frame(4'h8, 12'h042, 20, 0, 1'b1);
    idle(3);
    checks++; if (got_pcnt[3] !== 32'd1) begin errors++; $display("FAIL truncate ptr_cnt: got %0d expected 1", got_pcnt[3]); end
    checks++; if (got_plast !== 16'hC014) begin errors++; $display("FAIL truncate ptr_din: got %h expected c014", got_plast); end
    send_frame(4'h8, 12'd12, 10, 1, 1'b1);
    idle(4);
    for (int p = 0; p < 4; p++) begin
      checks++; if (got_cnt[p] !== exp_cnt[p]) begin errors++; $display("FAIL truncate wr_cnt[%0d]: got %0d expected %0d", p, got_cnt[p], exp_cnt[p]); end
      checks++; if (got_hash[p] !== exp_hash[p]) begin errors++; $display("FAIL truncate data[%0d]: got %h expected %h", p, got_hash[p], exp_hash[p]); end
      checks++; if (got_phash[p] !== exp_phash[p]) begin errors++; $display("FAIL truncate ptrs[%0d]: got %h expected %h", p, got_phash[p], exp_phash[p]); end
    end
    $display("test_truncate: port3 bytes=%0d ptrs=%0d", got_cnt[3], got_pcnt[3]);
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(4'h1, 12'd66, 64, 2, 1'b0);
    send_frame(4'h2, 12'd42, 40, 1, 1'b0);
    send_frame(4'h3, 12'd30, 10, 0, 1'b0);
    send_frame(4'h1, 12'd20, 18, 0, 1'b1);
    idle(4);
    for (int p = 0; p < 4; p++) begin
      checks++; if (got_cnt[p] !== exp_cnt[p]) begin errors++; $display("FAIL b2b wr_cnt[%0d]: got %0d expected %0d", p, got_cnt[p], exp_cnt[p]); end
      checks++; if (got_hash[p] !== exp_hash[p]) begin errors++; $display("FAIL b2b data[%0d]: got %h expected %h", p, got_hash[p], exp_hash[p]); end
      checks++; if (got_pcnt[p] !== exp_pcnt[p]) begin errors++; $display("FAIL b2b ptr_cnt[%0d]: got %0d expected %0d", p, got_pcnt[p], exp_pcnt[p]); end
      checks++; if (got_phash[p] !== exp_phash[p]) begin errors++; $display("FAIL b2b ptrs[%0d]: got %h expected %h", p, got_phash[p], exp_phash[p]); end
    end
    $display("test_back_to_back: port0 bytes=%0d port1 bytes=%0d", got_cnt[0], got_cnt[1]);
  endtask

  task automatic test_len_limits();
    clear_obs();
    space_v = {4{12'd2000}};
    send_frame(4'h1, 12'd1520, 1518, 1, 1'b1);
    send_frame(4'h1, 12'd1521, 3, 0, 1'b1);
    send_frame(4'h1, 12'd2, 0, 0, 1'b1);
    send_frame(4'h1, 12'd1, 2, 0, 1'b1);
    space_v[1] = 12'd100;
    send_frame(4'h2, 12'd102, 100, 1, 1'b1);
    space_v[1] = 12'd99;
    send_frame(4'h2, 12'd102, 100, 1, 1'b1);
    ptr_full_v = 4'b0100;
    space_v[1] = 12'd2000;
    send_frame(4'h6, 12'd12, 10, 1, 1'b1);
    send_frame(4'h0, 12'd20, 18, 0, 1'b1);
    ptr_full_v = 4'd0;
    idle(4);
    for (int p = 0; p < 4; p++) begin
      checks++; if (got_cnt[p] !== exp_cnt[p]) begin errors++; $display("FAIL limits wr_cnt[%0d]: got %0d expected %0d", p, got_cnt[p], exp_cnt[p]); end
      checks++; if (got_hash[p] !== exp_hash[p]) begin errors++; $display("FAIL limits data[%0d]: got %h expected %h", p, got_hash[p], exp_hash[p]); end
      checks++; if (got_phash[p] !== exp_phash[p]) begin errors++; $display("FAIL limits ptrs[%0d]: got %h expected %h", p, got_phash[p], exp_phash[p]); end
    end
    checks++; if (got_drop !== exp_drop) begin errors++; $display("FAIL limits drop: got %0d expected %0d", got_drop, exp_drop); end
    space_v = {4{12'd4095}};
    $display("test_len_limits: drops=%0d port0 bytes=%0d", got_drop, got_cnt[0]);
  endtask

  task automatic test_random();
    logic [11:0] len;
    int          kind, nsend, pad, r;
    bit          gap, trunc;
    clear_obs();
    for (int f = 0; f < 30; f++) begin
      for (int p = 0; p < 4; p++) begin
        r = $urandom_range(0, 9);
        space_v[p] = (r == 0) ? 12'($urandom_range(0, 60)) : (r == 1) ? 12'd1599 :
                     (r == 2) ? 12'd1600 : 12'($urandom_range(200, 4095));
      end
      ptr_full_v = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      kind  = $urandom_range(0, 9);
      len   = (kind == 0) ? 12'($urandom_range(0, 2)) :
              (kind == 1) ? 12'($urandom_range(1521, 4095)) : 12'($urandom_range(3, 150));
      trunc = (kind > 1) && ($urandom_range(0, 3) == 0);
      gap   = 1'($urandom_range(0, 1));
      nsend = (kind <= 1) ? $urandom_range(0, 5) :
              trunc ? $urandom_range(0, int'(len) - 3) : int'(len) - 2;
      pad   = trunc ? 0 : $urandom_range(gap ? 0 : 1, 5);
      send_frame(4'($urandom), len, nsend, pad, gap);
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (bp_vec[p] !== (space_v[p] < 12'd1600)) begin
          errors++; $display("FAIL random bp[%0d]: got %b expected %b (space %0d)", p, bp_vec[p], space_v[p] < 12'd1600, space_v[p]);
        end
      end
    end
    idle(4);
    for (int p = 0; p < 4; p++) begin
      checks++; if (got_cnt[p] !== exp_cnt[p]) begin errors++; $display("FAIL random wr_cnt[%0d]: got %0d expected %0d", p, got_cnt[p], exp_cnt[p]); end
      checks++; if (got_hash[p] !== exp_hash[p]) begin errors++; $display("FAIL random data[%0d]: got %h expected %h", p, got_hash[p], exp_hash[p]); end
      checks++; if (got_pcnt[p] !== exp_pcnt[p]) begin errors++; $display("FAIL random ptr_cnt[%0d]: got %0d expected %0d", p, got_pcnt[p], exp_pcnt[p]); end
      checks++; if (got_phash[p] !== exp_phash[p]) begin errors++; $display("FAIL random ptrs[%0d]: got %h expected %h", p, got_phash[p], exp_phash[p]); end
    end
    checks++; if (got_drop !== exp_drop) begin errors++; $display("FAIL random drop: got %0d expected %0d", got_drop, exp_drop); end
    space_v = {4{12'd4095}}; ptr_full_v = '0;
    $display("test_random: drops=%0d ptrs=%0d/%0d/%0d/%0d", got_drop, got_pcnt[0], got_pcnt[1], got_pcnt[2], got_pcnt[3]);
  endtask

  task automatic test_reset_mid();
    clear_obs();
    drive(1'b1, 1'b1, 8'h02);
    drive(1'b0, 1'b1, 8'd66);
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 8'($urandom));
    rstn    = 1'b0;
    space_v = {12'd3000, 12'd1600, 12'd1599, 12'd100};
    #1;
    checks++; if (dfifo_wr !== 4'd0) begin errors++; $display("FAIL reset_mid dfifo_wr: got %h expected 0", dfifo_wr); end
    checks++; if (ptr_wr !== 4'd0) begin errors++; $display("FAIL reset_mid ptr_wr: got %h expected 0", ptr_wr); end
    checks++; if (bp_vec !== 4'd0) begin errors++; $display("FAIL reset_mid bp: got %b expected 0000", bp_vec); end
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 8'($urandom));
    idle(1);
    rstn = 1'b1;
    idle(4);
    checks++; if (bp_vec !== 4'b0011) begin errors++; $display("FAIL reset_mid bp_release: got %b expected 0011", bp_vec); end
    for (int p = 0; p < 4; p++) begin
      checks++; if (got_pcnt[p] !== 32'd0) begin errors++; $display("FAIL reset_mid ptr_cnt[%0d]: got %0d expected 0", p, got_pcnt[p]); end
    end
    checks++; if (got_drop !== 32'd0) begin errors++; $display("FAIL reset_mid drop: got %0d expected 0", got_drop); end
    space_v = {4{12'd4095}};
    clear_obs();
    send_frame(4'h2, 12'd34, 32, 1, 1'b1);
    idle(4);
    checks++; if (got_cnt[1] !== exp_cnt[1]) begin errors++; $display("FAIL reset_mid post_cnt: got %0d expected %0d", got_cnt[1], exp_cnt[1]); end
    checks++; if (got_phash[1] !== exp_phash[1]) begin errors++; $display("FAIL reset_mid post_ptr: got %h expected %h", got_phash[1], exp_phash[1]); end
    $display("test_reset_mid: post-reset port1 bytes=%0d", got_cnt[1]);
  endtask

  initial begin
    ptr_full_v = '0;
    space_v    = '0;
    test_reset();
    test_unicast();
    test_broadcast();
    test_drop();
    test_truncate();
    test_back_to_back();
    test_len_limits();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
